// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one 32x32 sprite frame from the sprite ROM into the
// word-organised framebuffer at pixel (x,y). Each sprite row is split across at
// most two framebuffer words. Those words are updated by read-modify-write using
// OR or XOR, and the XOR mode reports when it clears a lit pixel.
module sprite_blitter #(
  parameter int FB_WPR     = 20,
  parameter int FB_ROWS    = 480,
  parameter int FRAME_ROWS = 32,
  parameter int NUM_FRAMES = 5,
  parameter int FB_AW      = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       frame,
  input  logic [9:0]       x,
  input  logic [8:0]       y,
  input  logic             xor_mode,
  output logic             busy,
  output logic             done,
  output logic             collision,
  output logic [7:0]       rom_addr,
  input  logic [31:0]      rom_data,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_rd_en,
  input  logic [31:0]      fb_rdata,
  output logic             fb_wr_en,
  output logic [31:0]      fb_wdata
);

  localparam int RW = $clog2(FRAME_ROWS);
  localparam logic [5:0] WPR = 6'(FB_WPR);
  localparam logic [3:0] NFRAMES = 4'(NUM_FRAMES);
  localparam logic [9:0] NROWS = 10'(FB_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_RD_L,
    S_WR_L,
    S_RD_R,
    S_WR_R,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]    frame_q;
  logic [4:0]    word_q;
  logic [4:0]    shift_q;
  logic [8:0]    y_q;
  logic          xor_q;
  logic [RW-1:0] row_q;

  logic [9:0]  row_y;
  logic [5:0]  word_r;
  logic        row_clip;
  logic        has_right;
  logic        last_row;
  logic        frame_ok;
  logic        row_end;
  logic [31:0] part_l;
  logic [31:0] part_r;
  logic [31:0] cur_part;
  logic [31:0] merged;
  logic [5:0]  cur_word;
  logic        right_side;

  // Row geometry, clipping decisions and the pixel data to merge into the current word
  always_comb begin
    row_y      = {1'b0, y_q} + 10'(row_q);
    word_r     = {1'b0, word_q} + 6'd1;
    row_clip   = (row_y >= NROWS) || ({1'b0, word_q} >= WPR);
    has_right  = (shift_q != 5'd0) && (word_r < WPR);
    last_row   = (row_q == RW'(FRAME_ROWS - 1));
    frame_ok   = ({1'b0, frame} < NFRAMES);
    right_side = (state == S_RD_R) || (state == S_WR_R);
    part_l     = rom_data >> shift_q;
    part_r     = rom_data << (6'd32 - {1'b0, shift_q});
    cur_part   = right_side ? part_r : part_l;
    merged     = xor_q ? (fb_rdata ^ cur_part) : (fb_rdata | cur_part);
    cur_word   = right_side ? word_r : {1'b0, word_q};
    row_end    = ((state == S_ROW) && row_clip) ||
                 ((state == S_WR_L) && !has_right) ||
                 (state == S_WR_R);
  end

  // State register; reset aborts any blit in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: ROW decides clip/draw, the last state of a row advances the row counter
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = frame_ok ? S_ROW : S_DONE;
        end
      end
      S_ROW: begin
        if (row_clip) begin
          state_nx = last_row ? S_DONE : S_ROW;
        end else begin
          state_nx = S_RD_L;
        end
      end
      S_RD_L: state_nx = S_WR_L;
      S_WR_L: begin
        if (has_right) begin
          state_nx = S_RD_R;
        end else begin
          state_nx = last_row ? S_DONE : S_ROW;
        end
      end
      S_RD_R: state_nx = S_WR_R;
      S_WR_R: state_nx = last_row ? S_DONE : S_ROW;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Blit parameters latched on an accepted start, row counter and sticky collision flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q   <= '0;
      word_q    <= '0;
      shift_q   <= '0;
      y_q       <= '0;
      xor_q     <= 1'b0;
      row_q     <= '0;
      collision <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      frame_q   <= frame;
      word_q    <= x[9:5];
      shift_q   <= x[4:0];
      y_q       <= y;
      xor_q     <= xor_mode;
      row_q     <= '0;
      collision <= 1'b0;
    end else begin
      if (row_end) begin
        row_q <= row_q + 1'b1;
      end
      if (fb_wr_en && xor_q && ((fb_rdata & cur_part) != 32'd0)) begin
        collision <= 1'b1;
      end
    end
  end

  // Memory-side strobes, addresses and write data decoded from the current state
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    fb_rd_en = (state == S_RD_L) || (state == S_RD_R);
    fb_wr_en = (state == S_WR_L) || (state == S_WR_R);
    rom_addr = 8'(32'(frame_q) * FRAME_ROWS + 32'(row_q));
    fb_addr  = '0;
    fb_wdata = 32'd0;
    if (fb_rd_en || fb_wr_en) begin
      fb_addr = FB_AW'(32'(row_y) * FB_WPR + 32'(cur_word));
    end
    if (fb_wr_en) begin
      fb_wdata = merged;
    end
  end

endmodule
